mem_stage: RTL and testbench

//  MIPS pipeline MEM stage. Sits between EX and WB.

---
 rtl/mem_stage_pkg.sv | 49 ++++
 rtl/mem_stage_load_align.sv | 40 ++++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS MEM stage: bus widths, stall encodings,
// mem_op bit positions, FSM state encodings and load-extension helpers.
package mem_stage_pkg;

  localparam int unsigned ExToMemWd = 84;
  localparam int unsigned MemToWbWd = 70;
  localparam int unsigned MemToRfWd = 38;
  localparam int unsigned StallBus  = 6;

  // Stall vector positions and encodings.
  localparam int unsigned StallMem = 3;
  localparam int unsigned StallWb  = 4;
  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;

  // mem_op is one-hot: {lb, lbu, lh, lhu, lw, sb, sh, sw}.
  localparam int unsigned OpLb  = 7;
  localparam int unsigned OpLbu = 6;
  localparam int unsigned OpLh  = 5;
  localparam int unsigned OpLhu = 4;
  localparam int unsigned OpLw  = 3;
  localparam int unsigned OpSb  = 2;
  localparam int unsigned OpSh  = 1;
  localparam int unsigned OpSw  = 0;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  typedef struct packed {
    logic [7:0]  mem_op;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  function automatic logic [31:0] extend8(input logic [7:0] b, input logic sign);
    return {{24{sign & b[7]}}, b};
  endfunction

  function automatic logic [31:0] extend16(input logic [15:0] h, input logic sign);
    return {{16{sign & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the little-endian
// read word and sign- or zero-extends it according to the one-hot mem_op.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_store_ops;

  assign unused_store_ops = ^mem_op[OpSb:OpSw];

  always_comb begin
    unique case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    // lw and anything that is not a sub-word load pass the word through.
    load_data = rdata;
    if (mem_op[OpLb]) begin
      load_data = extend8(byte_sel, 1'b1);
    end else if (mem_op[OpLbu]) begin
      load_data = extend8(byte_sel, 1'b0);
    end else if (mem_op[OpLh]) begin
      load_data = extend16(half_sel, 1'b1);
    end else if (mem_op[OpLhu]) begin
      load_data = extend16(half_sel, 1'b0);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: registers the EX->MEM bus, waits for load data, and drives the
// WB bus, the ID forwarding bus and a stall request. Optional MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [StallBus-1:0]  stall,
  input  logic [ExToMemWd-1:0] ex_to_mem_bus,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 data_sram_data_ok,
  output logic [MemToWbWd-1:0] mem_to_wb_bus,
  output logic [MemToRfWd-1:0] mem_to_rf_bus,
  output logic                 stallreq_for_mem,
  output logic                 excp_adel,
  output logic [31:0]          excp_badvaddr
);

  ex_to_mem_t  bus_q;
  logic [1:0]  state_q, state_d;
  logic [31:0] hold_q, hold_d;

  logic        is_load;
  logic        stallreq;
  logic [1:0]  addr_lo;
  logic [31:0] load_src;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        rf_we_out;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};

  // A bubble is injected when MEM stops but WB keeps moving.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
    end else if (stall[StallMem] == Stop && stall[StallWb] == NoStop) begin
      bus_q <= '0;
    end else if (stall[StallMem] == NoStop) begin
      bus_q <= ex_to_mem_bus;
    end
  end

  assign is_load = bus_q.ram_en & (bus_q.ram_wen == 4'h0) & (|bus_q.mem_op[OpLb:OpLw]);
  assign addr_lo = bus_q.ex_result[1:0];

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    stallreq = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_load) begin
          if (!data_sram_data_ok) begin
            state_d  = StWait;
            stallreq = 1'b1;
          end else if (stall[StallMem] == Stop) begin
            state_d = StHold;
            hold_d  = data_sram_rdata;
          end
        end
      end
      StWait: begin
        if (!data_sram_data_ok) begin
          stallreq = 1'b1;
        end else if (stall[StallMem] == Stop) begin
          // Another stage still holds MEM; keep the data until we advance.
          state_d = StHold;
          hold_d  = data_sram_rdata;
        end else begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (stall[StallMem] == NoStop) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign load_src = (state_q == StHold) ? hold_q : data_sram_rdata;

  mem_stage_load_align u_load_align (
    .mem_op    (bus_q.mem_op),
    .addr      (addr_lo),
    .rdata     (load_src),
    .load_data (load_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((bus_q.mem_op[OpLh] | bus_q.mem_op[OpLhu]) & addr_lo[0]) |
                      (bus_q.mem_op[OpLw] & (addr_lo != 2'b00));
  assign excp_adel     = is_load & misaligned;
  assign excp_badvaddr = excp_adel ? bus_q.ex_result : 32'h0;
`else
  assign excp_adel     = 1'b0;
  assign excp_badvaddr = 32'h0;
`endif

  assign rf_we_out = bus_q.rf_we & ~excp_adel;
  assign rf_wdata  = bus_q.sel_rf_res ? load_data : bus_q.ex_result;

  assign mem_to_wb_bus    = {bus_q.pc, rf_we_out, bus_q.rf_waddr, rf_wdata};
  assign mem_to_rf_bus    = {rf_we_out, bus_q.rf_waddr, rf_wdata};
  assign stallreq_for_mem = stallreq;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extraction, late data, hold, bubble, store,
// mid-wait reset and misaligned-load flagging (follows MEM_ALIGN_CHECK_EN).
module tb_mem_stage;

  localparam logic [5:0] Run    = 6'b000000;
  localparam logic [5:0] Freeze = 6'b011111;
  localparam logic [5:0] Bubble = 6'b001000;

  localparam logic [7:0] OpLb  = 8'h80;
  localparam logic [7:0] OpLbu = 8'h40;
  localparam logic [7:0] OpLh  = 8'h20;
  localparam logic [7:0] OpLw  = 8'h08;
  localparam logic [7:0] OpSw  = 8'h01;

  localparam logic [31:0] Rd1 = 32'h1234_80FF;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [83:0] ex_to_mem_bus;
  logic [31:0] rdata;
  logic        data_ok;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic        stallreq_for_mem;
  logic        excp_adel;
  logic [31:0] excp_badvaddr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .ex_to_mem_bus     (ex_to_mem_bus),
    .data_sram_rdata   (rdata),
    .data_sram_data_ok (data_ok),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .mem_to_rf_bus     (mem_to_rf_bus),
    .stallreq_for_mem  (stallreq_for_mem),
    .excp_adel         (excp_adel),
    .excp_badvaddr     (excp_badvaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [83:0] ld(input logic [7:0] op, input logic [31:0] pc,
                                     input logic [31:0] addr, input logic [4:0] wa);
    return {op, pc, 1'b1, 4'h0, 1'b1, 1'b1, wa, addr};
  endfunction

  function automatic logic [83:0] st(input logic [7:0] op, input logic [31:0] pc,
                                     input logic [31:0] addr);
    return {op, pc, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, addr};
  endfunction

  function automatic logic [83:0] alu(input logic [31:0] pc, input logic [4:0] wa,
                                      input logic [31:0] res);
    return {8'h00, pc, 1'b0, 4'h0, 1'b0, 1'b1, wa, res};
  endfunction

  function automatic logic [69:0] wb(input logic [31:0] pc, input logic we,
                                     input logic [4:0] wa, input logic [31:0] d);
    return {pc, we, wa, d};
  endfunction

  task automatic drive(input logic [83:0] b, input logic [5:0] s, input logic ok,
                       input logic [31:0] rd);
    ex_to_mem_bus = b;
    stall         = s;
    data_ok       = ok;
    rdata         = rd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wb"}, mem_to_wb_bus, 70'h0);
    check({tag, "_rf"}, 70'(mem_to_rf_bus), 70'h0);
    check({tag, "_stallreq"}, 70'(stallreq_for_mem), 70'h0);
    check({tag, "_adel"}, 70'(excp_adel), 70'h0);
    check({tag, "_badvaddr"}, 70'(excp_badvaddr), 70'h0);
  endtask

  initial begin
    logic [69:0] exp_wb;

    // Reset with garbage on the inputs.
    rst = 1'b1;
    drive(ld(OpLw, 32'hBFC0_0000, 32'h0, 5'd1), Run, 1'b1, 32'hFFFF_FFFF);
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;

    // 1. Extraction with data_ok in the same cycle; next load issued each edge.
    drive(ld(OpLb, 32'h0000_0100, 32'h8000_0001, 5'd1), Run, 1'b0, 32'h0);
    tick();
    drive(ld(OpLbu, 32'h0000_0104, 32'h8000_0001, 5'd2), Run, 1'b1, Rd1);
    exp_wb = wb(32'h0000_0100, 1'b1, 5'd1, 32'hFFFF_FF80);
    check("lb_wb", mem_to_wb_bus, exp_wb);
    check("lb_rf", 70'(mem_to_rf_bus), 70'(exp_wb[37:0]));
    check("lb_stallreq", 70'(stallreq_for_mem), 70'h0);
    tick();
    drive(ld(OpLh, 32'h0000_0108, 32'h8000_0002, 5'd3), Run, 1'b1, Rd1);
    check("lbu_wb", mem_to_wb_bus, wb(32'h0000_0104, 1'b1, 5'd2, 32'h0000_0080));
    tick();
    drive(ld(OpLw, 32'h0000_010C, 32'h8000_0000, 5'd4), Run, 1'b1, Rd1);
    check("lh_wb", mem_to_wb_bus, wb(32'h0000_0108, 1'b1, 5'd3, 32'h0000_1234));
    tick();
    drive(84'h0, Run, 1'b1, Rd1);
    check("lw_wb", mem_to_wb_bus, wb(32'h0000_010C, 1'b1, 5'd4, Rd1));
    check("lw_adel", 70'(excp_adel), 70'h0);
    tick();

    // 2. Data arrives two cycles late.
    drive(ld(OpLw, 32'h0000_0200, 32'h0000_0004, 5'd7), Run, 1'b0, 32'h0);
    tick();
    drive(84'h0, Freeze, 1'b0, 32'h0);
    check("late_stall0", 70'(stallreq_for_mem), 70'h1);
    tick();
    drive(84'h0, Freeze, 1'b0, 32'h0);
    check("late_stall1", 70'(stallreq_for_mem), 70'h1);
    tick();
    drive(84'h0, Run, 1'b1, 32'hCAFE_F00D);
    check("late_stall2", 70'(stallreq_for_mem), 70'h0);
    check("late_wb", mem_to_wb_bus, wb(32'h0000_0200, 1'b1, 5'd7, 32'hCAFE_F00D));
    tick();
    drive(84'h0, Run, 1'b0, 32'h0);
    check("late_after_stall", 70'(stallreq_for_mem), 70'h0);
    check("late_after_wb", mem_to_wb_bus, 70'h0);

    // 3. Data arrives while MEM is frozen by someone else: must be held.
    drive(ld(OpLw, 32'h0000_0300, 32'h0000_0008, 5'd9), Run, 1'b0, 32'h0);
    tick();
    drive(84'h0, Freeze, 1'b1, 32'h5A5A_1234);
    check("hold_capture_stall", 70'(stallreq_for_mem), 70'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(84'h0, Freeze, (i == 1), 32'hDEAD_BEE0 + 32'(i));
      check($sformatf("hold_wb%0d", i), mem_to_wb_bus,
            wb(32'h0000_0300, 1'b1, 5'd9, 32'h5A5A_1234));
      check($sformatf("hold_stall%0d", i), 70'(stallreq_for_mem), 70'h0);
      tick();
    end
    drive(ld(OpLw, 32'h0000_0310, 32'h0000_000C, 5'd10), Run, 1'b0, 32'hDEAD_BEEF);
    check("hold_release_wb", mem_to_wb_bus, wb(32'h0000_0300, 1'b1, 5'd9, 32'h5A5A_1234));
    tick();
    // FSM back in IDLE: fresh rdata is used directly.
    drive(84'h0, Run, 1'b1, 32'h0BAD_F00D);
    check("post_hold_wb", mem_to_wb_bus, wb(32'h0000_0310, 1'b1, 5'd10, 32'h0BAD_F00D));
    tick();

    // 4. Bubble insertion, then a store.
    drive(alu(32'h0000_0400, 5'd5, 32'h1111_2222), Run, 1'b0, 32'h0);
    tick();
    drive(alu(32'h0000_0404, 5'd6, 32'h3333_4444), Bubble, 1'b0, 32'h0);
    check("alu_wb", mem_to_wb_bus, wb(32'h0000_0400, 1'b1, 5'd5, 32'h1111_2222));
    tick();
    drive(st(OpSw, 32'h0000_0410, 32'h0000_0010), Run, 1'b0, 32'h0);
    check("bubble_wb", mem_to_wb_bus, 70'h0);
    tick();
    drive(84'h0, Run, 1'b0, 32'h0);
    check("sw_rf_we", 70'(mem_to_wb_bus[37]), 70'h0);
    check("sw_stallreq", 70'(stallreq_for_mem), 70'h0);
    tick();

    // 5. Reset while waiting, with MEM frozen.
    drive(ld(OpLw, 32'h0000_0500, 32'h0000_0014, 5'd11), Run, 1'b0, 32'h0);
    tick();
    drive(84'h0, Freeze, 1'b0, 32'h0);
    check("rstwait_stall", 70'(stallreq_for_mem), 70'h1);
    tick();
    rst = 1'b1;
    drive(84'h0, Freeze, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    drive(84'h0, Freeze, 1'b0, 32'h0);
    check_quiet("rstwait");
    tick();

    // 6. Misaligned lw.
    drive(ld(OpLw, 32'h0000_0600, 32'h0000_0102, 5'd12), Run, 1'b0, 32'h0);
    tick();
    drive(84'h0, Run, 1'b1, Rd1);
`ifdef MEM_ALIGN_CHECK_EN
    check("adel", 70'(excp_adel), 70'h1);
    check("badvaddr", 70'(excp_badvaddr), 70'h102);
    check("adel_wb", mem_to_wb_bus, wb(32'h0000_0600, 1'b0, 5'd12, Rd1));
`else
    check("adel", 70'(excp_adel), 70'h0);
    check("badvaddr", 70'(excp_badvaddr), 70'h0);
    check("adel_wb", mem_to_wb_bus, wb(32'h0000_0600, 1'b1, 5'd12, Rd1));
`endif
    tick();
    drive(84'h0, Run, 1'b0, 32'h0);
    check_quiet("after_adel");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
